inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
// - Sequences the instruction ROM: owns the PC, drives the ROM chip-enable/address, and captures the ROM word each cycle.
// - Buffers fetched words with their PCs in a small FIFO and presents them to the decode stage with a valid/ready handshake.
// - Supports branch redirect, which flushes the buffer, and halt, which stops fetch. Sits between the ROM and the IF/ID stage.
// PARAMETERS
// - ADDR_W     32           PC / ROM address width
// - INST_W     32           instruction width
// - DEPTH      2            prefetch FIFO entries (power of two, >=2)
// - RESET_PC   32'h0        PC loaded at reset
// PORTS
// - clk            in   1        clock, all state updates on posedge
// - rst_n          in   1        asynchronous active-low reset
// - o_romEnable    out  1        ROM chip enable (`ENABLE when fetching)
// - o_romAddr      out  ADDR_W   ROM byte address (= PC)
// - i_romInst      in   INST_W   ROM data; combinational, valid in the same cycle as o_romAddr
// - i_branchValid  in   1        redirect request
// - i_branchTarget in   ADDR_W   redirect byte address
// - i_halt         in   1        stop fetching after this cycle
// - o_instValid    out  1        FIFO head valid
// - o_inst         out  INST_W   FIFO head instruction
// - o_instPc       out  ADDR_W   FIFO head PC
// - i_instReady    in   1        decode accepts head when o_instValid && i_instReady
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, PC=RESET_PC, FIFO empty, o_romEnable=0, o_romAddr=RESET_PC, o_instValid=0, o_inst=`ZERO_WORD, o_instPc=0.
// - States: IDLE -> FETCH on the first edge after reset release. FETCH -> HALTED when i_halt=1 and i_branchValid=0. HALTED -> FETCH on i_branchValid.
// - FETCH: o_romEnable=1 iff (count<DEPTH) or (count==DEPTH and pop this cycle). On an enabled edge, push {PC, i_romInst} and set PC<=PC+4.
// - PC wraps modulo 2^ADDR_W (all-ones-minus-3 + 4 -> 0).
// - IDLE/HALTED: o_romEnable=0 and no push. HALTED still drains the FIFO through the handshake.
// - Latency: first o_instValid=1 on the second edge after reset release (one IDLE cycle plus one fetch cycle). Steady state is one instruction per cycle with no bubbles.
// - Outputs are registered FIFO head fields. o_inst/o_instPc hold their last value while o_instValid=0; they never change while o_instValid=1 && !i_instReady.
// - Redirect (highest priority): on an edge with i_branchValid=1, FIFO cleared, PC<=i_branchTarget with bits[1:0] forced to 0, no push, state<=FETCH. Any pop in the same cycle is discarded. o_instValid=0 the next cycle.
// - Simultaneous push+pop when full is allowed; count is unchanged.
// - i_halt and i_branchValid in the same cycle: redirect wins, state stays FETCH.
// - While o_romEnable=0, o_romAddr still shows PC; the ROM outputs `ZERO_WORD and that value is never pushed.
// CONFIGURATION
// - FETCH_PERF_EN defined: adds outputs o_fetchCount[31:0] (pushes) and o_stallCount[31:0] (FETCH cycles with the FIFO full and no pop).
//   Both reset to 0, saturate at all-ones, and are unaffected by redirect.
// - FETCH_PERF_EN not defined: both ports and counters are absent; all other behaviour is identical.
// STRUCTURE
// - Shared defines header: FETCH_IDLE/FETCH_RUN/FETCH_HALTED state encodings (2 bits), `ENABLE/`DISABLE, `ZERO_WORD, RESET_PC default, PC_STEP=4.
// - Sub-module fetch_fifo: DEPTH-entry {ADDR_W+INST_W} FIFO with push, pop, flush, full, empty and count. Pointers are log2(DEPTH) bits plus a wrap bit; flush has priority over push and pop.
// - Top level contains the FSM, the PC register, ROM enable logic and the optional perf counters.
// TESTING
// - Reset release, i_instReady=1, ROM word[i]=i: o_romEnable rises one cycle after release. o_instValid=1 on the second edge with o_instPc=0, o_inst=0, then PCs 4, 8, 12 on consecutive cycles.
// - i_instReady=0 for 5 cycles: the FIFO fills to DEPTH and o_romEnable drops. The head holds PC=0 stably. After ready returns, PCs 0, 4, 8 come out in order with no duplicates or skips.
// - Redirect to 0x42 while the FIFO is full: o_instValid=0 the next cycle, then o_instPc=0x40, 0x44. Old entries never appear.
// - i_halt with a full FIFO: o_romEnable=0 from the next cycle and the buffered entries drain. A later redirect to 0x10 resumes fetch at PC 0x10.
// - Assert rst_n=0 mid-stream: all outputs reach reset values immediately (asynchronously). PC restarts at RESET_PC.
// - FETCH_PERF_EN: after 8 pushes and 3 full-stall cycles, o_fetchCount=8 and o_stallCount=3. Without the macro, the bench compiles with the ports absent.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch controller: FSM state
// encodings, enable levels, the idle ROM word, the default reset PC and
// the PC increment.
package inst_fetch_ctrl_pkg;

    // FSM state encodings (2 bits)
    localparam logic [1:0] FETCH_IDLE   = 2'd0;
    localparam logic [1:0] FETCH_RUN    = 2'd1;
    localparam logic [1:0] FETCH_HALTED = 2'd2;

    // ROM chip-enable levels
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Word the ROM returns while disabled; also the reset value of o_inst
    localparam logic [31:0] ZERO_WORD = 32'h0;

    // Default PC after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

    // Byte distance between consecutive instructions
    localparam int PC_STEP = 4;

endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// fetch_fifo: DEPTH-entry prefetch buffer holding {pc, inst} pairs.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter. Flush wins over push and pop; a push while
// full is only accepted when a pop frees a slot in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[PTR_W-1:0]];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // Pointer update: flush empties the buffer, otherwise advance on accepted ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; cleared at reset so the head reads zero before any fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: owns the PC, drives the instruction ROM and buffers the
// fetched words with their PCs for the decode stage.
// Optional feature macro: FETCH_PERF_EN adds saturating push and stall
// counters (o_fetchCount, o_stallCount).
//
// Handshake: decode takes the head entry on every rising edge where
// o_instValid && i_instReady; o_inst/o_instPc are stable while
// o_instValid && !i_instReady and hold their last value while o_instValid=0.
// A redirect (i_branchValid) discards the buffer, including any entry
// handed over in that same cycle.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   o_romEnable,
    output logic [ADDR_W-1:0]      o_romAddr,
    input  logic [INST_W-1:0]      i_romInst,
    input  logic                   i_branchValid,
    input  logic [ADDR_W-1:0]      i_branchTarget,
    input  logic                   i_halt,
    output logic                   o_instValid,
    output logic [INST_W-1:0]      o_inst,
    output logic [ADDR_W-1:0]      o_instPc,
    input  logic                   i_instReady,
`ifdef FETCH_PERF_EN
    output logic [31:0]            o_fetchCount,
    output logic [31:0]            o_stallCount,
`endif
    output logic [1:0]             dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int ENTRY_W = ADDR_W + INST_W;

    logic [1:0]             state;
    logic [ADDR_W-1:0]      pc;
    logic                   rom_en;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [ENTRY_W-1:0]     fifo_rdata;
    logic [ADDR_W-1:0]      head_pc;
    logic [INST_W-1:0]      head_inst;
    logic [ADDR_W-1:0]      last_pc;
    logic [INST_W-1:0]      last_inst;

    assign pop  = !fifo_empty && i_instReady;
    assign push = rom_en && !i_branchValid;

    // ROM enable: fetch only while running and a slot is (or becomes) free
    always_comb begin
        rom_en = DISABLE;
        if (state == FETCH_RUN && (!fifo_full || pop)) rom_en = ENABLE;
    end

    // FSM and PC: redirect overrides everything, otherwise step on each push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_IDLE;
            pc    <= RESET_PC;
        end else if (i_branchValid) begin
            state <= FETCH_RUN;
            pc    <= {i_branchTarget[ADDR_W-1:2], 2'b00};
        end else begin
            if (push) pc <= pc + ADDR_W'(PC_STEP);
            case (state)
                FETCH_IDLE:   state <= FETCH_RUN;
                FETCH_RUN:    if (i_halt) state <= FETCH_HALTED;
                FETCH_HALTED: state <= FETCH_HALTED;
                default:      state <= FETCH_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (i_branchValid),
        .wdata ({pc, i_romInst}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_pc   = fifo_rdata[ENTRY_W-1:INST_W];
    assign head_inst = fifo_rdata[INST_W-1:0];

    // Remember the most recent head so the outputs hold once the buffer empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc   <= '0;
            last_inst <= INST_W'(ZERO_WORD);
        end else if (!fifo_empty) begin
            last_pc   <= head_pc;
            last_inst <= head_inst;
        end
    end

    assign o_romEnable = rom_en;
    assign o_romAddr   = pc;
    assign o_instValid = !fifo_empty;
    assign o_inst      = fifo_empty ? last_inst : head_inst;
    assign o_instPc    = fifo_empty ? last_pc   : head_pc;
    assign dbg_state   = state;
    assign dbg_count   = fifo_count;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    // Saturating counters of pushes and of running cycles blocked by a full buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
            if (state == FETCH_RUN && fifo_full && !pop && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_fetchCount = fetch_cnt;
    assign o_stallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl. Inputs change on the falling edge; outputs
// are sampled 3 ns later, ahead of the next rising edge. The ROM model
// returns word index (addr >> 2) while enabled and zero otherwise.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_enable;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        halt;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .o_romEnable    (rom_enable),
    .o_romAddr      (rom_addr),
    .i_romInst      (rom_inst),
    .i_branchValid  (branch_valid),
    .i_branchTarget (branch_target),
    .i_halt         (halt),
    .o_instValid    (inst_valid),
    .o_inst         (inst),
    .o_instPc       (inst_pc),
    .i_instReady    (inst_ready),
`ifdef FETCH_PERF_EN
    .o_fetchCount   (fetch_count),
    .o_stallCount   (stall_count),
`endif
    .dbg_state      (dbg_state),
    .dbg_count      (dbg_count)
  );

  // ROM model
  assign rom_inst = rom_enable ? {2'b00, rom_addr[31:2]} : 32'h0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // scoreboard: expected delivery for an instruction fetched from pc
  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, 2'b00, pc[31:2]});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: every accepted handshake must match the head of the queue
  always begin
    logic [63:0] got;
    logic [63:0] exp;
    @(negedge clk);
    #3;
    if (rst_n && inst_valid && inst_ready) begin
      got = {inst_pc, inst};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst got pc=%0h inst=%0h with empty queue", inst_pc, inst);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL inst_stream got pc=%0h inst=%0h exp pc=%0h inst=%0h",
                   got[63:32], got[31:0], exp[63:32], exp[31:0]);
        end
      end
    end
  end

  // driver
  initial begin
    rst_n = 1'b0; inst_ready = 1'b0; branch_valid = 1'b0;
    branch_target = 32'h0; halt = 1'b0;
    step(2);
    #3;
    chk("reset_rom_enable", 64'(rom_enable), 64'h0);
    chk("reset_rom_addr",   64'(rom_addr),   64'h0);
    chk("reset_valid",      64'(inst_valid), 64'h0);
    chk("reset_inst",       64'(inst),       64'h0);
    chk("reset_inst_pc",    64'(inst_pc),    64'h0);
    chk("reset_state",      64'(dbg_state),  64'(FETCH_IDLE));

    // startup latency and streaming
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    step(1); rst_n = 1'b1; inst_ready = 1'b1;            // C0
    #3;
    chk("c0_rom_enable", 64'(rom_enable), 64'h0);
    chk("c0_valid",      64'(inst_valid), 64'h0);
    step(1); #3;                                         // C1
    chk("c1_rom_enable", 64'(rom_enable), 64'h1);
    chk("c1_rom_addr",   64'(rom_addr),   64'h0);
    chk("c1_valid",      64'(inst_valid), 64'h0);
    step(1); #3;                                         // C2
    chk("c2_valid",      64'(inst_valid), 64'h1);
    step(3);                                             // C3..C5

    // backpressure fills the buffer
    expect_pc(32'h10); expect_pc(32'h14); expect_pc(32'h18);
    step(1); inst_ready = 1'b0;                          // C6
    step(1); #3;                                         // C7
    chk("full_rom_enable", 64'(rom_enable), 64'h0);
    chk("full_count",      64'(dbg_count),  64'h2);
    for (int i = 0; i < 3; i++) begin                    // C8..C10
      step(1); #3;
      chk("stall_head_pc",   64'(inst_pc),    64'h10);
      chk("stall_head_inst", 64'(inst),       64'h4);
      chk("stall_valid",     64'(inst_valid), 64'h1);
    end
    step(1); inst_ready = 1'b1; #3;                      // C11
    chk("full_pop_rom_enable", 64'(rom_enable), 64'h1);
    step(2);                                             // C12, C13

    // redirect while full
    step(1); inst_ready = 1'b0; branch_valid = 1'b1; branch_target = 32'h42;  // C14
    #3;
    chk("pre_redirect_count", 64'(dbg_count), 64'h2);
    expect_pc(32'h40); expect_pc(32'h44);
    step(1); branch_valid = 1'b0; inst_ready = 1'b1; #3; // C15
    chk("redirect_valid_low", 64'(inst_valid), 64'h0);
    chk("redirect_rom_addr",  64'(rom_addr),   64'h40);
    step(2);                                             // C16, C17

    // halt with a full buffer, then drain
    step(1); inst_ready = 1'b0;                          // C18
    step(1); halt = 1'b1; #3;                            // C19
    chk("pre_halt_count", 64'(dbg_count), 64'h2);
    expect_pc(32'h48); expect_pc(32'h4C);
    step(1); halt = 1'b0; inst_ready = 1'b1; #3;         // C20
    chk("halt_rom_enable", 64'(rom_enable), 64'h0);
    chk("halt_state",      64'(dbg_state),  64'(FETCH_HALTED));
    step(1); #3;                                         // C21
    chk("halt_rom_enable2", 64'(rom_enable), 64'h0);
    step(1); #3;                                         // C22
    chk("drained_valid",   64'(inst_valid), 64'h0);
    chk("hold_inst_pc",    64'(inst_pc),    64'h4C);
    chk("hold_inst",       64'(inst),       64'h13);
    chk("halt_rom_enable3", 64'(rom_enable), 64'h0);
    step(1);                                             // C23
    expect_pc(32'h10); expect_pc(32'h14);
    step(1); branch_valid = 1'b1; branch_target = 32'h10;   // C24
    step(1); branch_valid = 1'b0; #3;                    // C25
    chk("resume_valid",      64'(inst_valid), 64'h0);
    chk("resume_rom_enable", 64'(rom_enable), 64'h1);
    chk("resume_rom_addr",   64'(rom_addr),   64'h10);
    step(2);                                             // C26, C27

    // halt and redirect together: redirect wins
    step(1); inst_ready = 1'b0; halt = 1'b1; branch_valid = 1'b1;
    branch_target = 32'h103;                             // C28
    expect_pc(32'h100); expect_pc(32'h104);
    step(1); halt = 1'b0; branch_valid = 1'b0; inst_ready = 1'b1; #3;  // C29
    chk("both_valid",      64'(inst_valid), 64'h0);
    chk("both_state",      64'(dbg_state),  64'(FETCH_RUN));
    chk("both_rom_enable", 64'(rom_enable), 64'h1);
    chk("both_rom_addr",   64'(rom_addr),   64'h100);
    step(2);                                             // C30, C31

    // PC wrap at the top of the address space
    step(1); inst_ready = 1'b0; branch_valid = 1'b1; branch_target = 32'hFFFF_FFFF;  // C32
    expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    step(1); branch_valid = 1'b0; inst_ready = 1'b1; #3; // C33
    chk("wrap_rom_addr", 64'(rom_addr), 64'hFFFF_FFFC);
    step(2);                                             // C34, C35

    // asynchronous reset mid-stream
    step(1); inst_ready = 1'b0;                          // C36
    #1; rst_n = 1'b0; #1;
    chk("async_rom_enable", 64'(rom_enable), 64'h0);
    chk("async_rom_addr",   64'(rom_addr),   64'h0);
    chk("async_valid",      64'(inst_valid), 64'h0);
    chk("async_inst",       64'(inst),       64'h0);
    chk("async_inst_pc",    64'(inst_pc),    64'h0);
    chk("async_state",      64'(dbg_state),  64'(FETCH_IDLE));
    step(1);
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    step(1); rst_n = 1'b1; inst_ready = 1'b1;            // R0
    step(1); #3;                                         // R1
    chk("restart_rom_addr", 64'(rom_addr), 64'h0);
    step(7); inst_ready = 1'b0;                          // R8
    step(3);                                             // R9..R11
    step(1); inst_ready = 1'b1; #3;                      // R12
`ifdef FETCH_PERF_EN
    chk("perf_fetch_count", 64'(fetch_count), 64'h8);
    chk("perf_stall_count", 64'(stall_count), 64'h3);
`endif
    step(1);                                             // R13
    step(1); inst_ready = 1'b0;                          // R14
    step(3); #3;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
